// File: rtl/xadc_dual_reader.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module : xadc_dual_reader
// Reads XADC VAUX3 (left) / VAUX2 (right) over DRP on each EOC, box-car
// averages 2^AVG_LOG2 pairs and publishes 12-bit samples with a strobe.
// Rev    : 1.0
// =====================================================================
module xadc_dual_reader #(
    parameter int         AVG_LOG2 = 2,
    parameter int         TIMEOUT  = 255,
    parameter logic [6:0] ADDR_L   = 7'h13,
    parameter logic [6:0] ADDR_R   = 7'h12
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        eoc_in,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic        den_out,
    output logic        dwe_out,
    output logic [6:0]  daddr_out,
    output logic [15:0] vauxp3,
    output logic [15:0] vauxp2,
    output logic        sample_valid,
    output logic        timeout_err
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int PW = AVG_LOG2 + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] c_LAST_PAIR = PW'((1 << AVG_LOG2) - 1);
    localparam logic [CW-1:0] c_TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_TO_EXPIRE = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ_L  = 3'd1,
        S_WAIT_L = 3'd2,
        S_REQ_R  = 3'd3,
        S_WAIT_R = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            den_q, den_d;
    logic [6:0]      daddr_q, daddr_d;
    logic [11:0]     left_q, left_d;
    logic [AW-1:0]   acc_l_q, acc_l_d;
    logic [AW-1:0]   acc_r_q, acc_r_d;
    logic [PW-1:0]   pair_q, pair_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;
    logic [11:0]     p3_q, p3_d;
    logic [11:0]     p2_q, p2_d;
    logic            valid_q, valid_d;
    logic            to_q, to_d;

    logic [AW-1:0]   w_sum_l;
    logic [AW-1:0]   w_sum_r;
    logic            w_unused;

    assign w_sum_l  = acc_l_q + AW'(left_q);
    assign w_sum_r  = acc_r_q + AW'(do_in[15:4]);
    assign w_unused = ^do_in[3:0];

    always_comb begin
        state_d = state_q;
        den_d   = 1'b0;
        daddr_d = daddr_q;
        left_d  = left_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        pair_d  = pair_q;
        tcnt_d  = tcnt_q;
        p3_d    = p3_q;
        p2_d    = p2_q;
        valid_d = 1'b0;
        to_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (eoc_in) begin
                    state_d = S_REQ_L;
                    den_d   = 1'b1;
                    daddr_d = ADDR_L;
                end
            end
            S_REQ_L: begin
                state_d = S_WAIT_L;
                tcnt_d  = '0;
            end
            S_REQ_R: begin
                state_d = S_WAIT_R;
                tcnt_d  = '0;
            end
            S_WAIT_L, S_WAIT_R: begin
                // timeout_err fires on the edge the count reaches TIMEOUT;
                // the following (expiry) cycle only returns to IDLE.
                if (tcnt_q == c_TO_EXPIRE) begin
                    state_d = S_IDLE;
                end else if (drdy_in && state_q == S_WAIT_L) begin
                    left_d  = do_in[15:4];
                    state_d = S_REQ_R;
                    den_d   = 1'b1;
                    daddr_d = ADDR_R;
                end else if (drdy_in) begin
                    state_d = S_IDLE;
                    if (pair_q == c_LAST_PAIR) begin
                        p3_d    = w_sum_l[AW-1:AVG_LOG2];
                        p2_d    = w_sum_r[AW-1:AVG_LOG2];
                        valid_d = 1'b1;
                        acc_l_d = '0;
                        acc_r_d = '0;
                        pair_d  = '0;
                    end else begin
                        acc_l_d = w_sum_l;
                        acc_r_d = w_sum_r;
                        pair_d  = pair_q + PW'(1);
                    end
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                    if (tcnt_q == c_TO_LAST) begin
                        to_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            den_q   <= 1'b0;
            daddr_q <= ADDR_L;
            left_q  <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            pair_q  <= '0;
            tcnt_q  <= '0;
            p3_q    <= '0;
            p2_q    <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            den_q   <= den_d;
            daddr_q <= daddr_d;
            left_q  <= left_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            pair_q  <= pair_d;
            tcnt_q  <= tcnt_d;
            p3_q    <= p3_d;
            p2_q    <= p2_d;
            valid_q <= valid_d;
            to_q    <= to_d;
        end
    end

    assign den_out      = den_q;
    assign dwe_out      = 1'b0;
    assign daddr_out    = daddr_q;
    assign vauxp3       = {4'b0000, p3_q};
    assign vauxp2       = {4'b0000, p2_q};
    assign sample_valid = valid_q;
    assign timeout_err  = to_q;

endmodule
`default_nettype wire

// File: tb/tb_xadc_dual_reader.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module : tb_xadc_dual_reader
// Drives two reader instances (AVG_LOG2 = 0 and 2) with one DRP stream
// and checks them against a transaction-level expectation timeline.
// Rev    : 1.0
// =====================================================================
module tb_xadc_dual_reader;
    localparam int T = 8;
    localparam int N = 20000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        eoc_in = 1'b0;
    logic        drdy_in = 1'b0;
    logic [15:0] do_in = 16'h0000;

    logic        den_o   [0:1];
    logic        dwe_o   [0:1];
    logic [6:0]  addr_o  [0:1];
    logic [15:0] p3_o    [0:1];
    logic [15:0] p2_o    [0:1];
    logic        valid_o [0:1];
    logic        to_o    [0:1];

    xadc_dual_reader #(.AVG_LOG2(0), .TIMEOUT(T)) u_a (
        .CLK100MHZ(clk), .reset(reset), .eoc_in(eoc_in), .drdy_in(drdy_in), .do_in(do_in),
        .den_out(den_o[0]), .dwe_out(dwe_o[0]), .daddr_out(addr_o[0]), .vauxp3(p3_o[0]),
        .vauxp2(p2_o[0]), .sample_valid(valid_o[0]), .timeout_err(to_o[0]));

    xadc_dual_reader #(.AVG_LOG2(2), .TIMEOUT(T)) u_b (
        .CLK100MHZ(clk), .reset(reset), .eoc_in(eoc_in), .drdy_in(drdy_in), .do_in(do_in),
        .den_out(den_o[1]), .dwe_out(dwe_o[1]), .daddr_out(addr_o[1]), .vauxp3(p3_o[1]),
        .vauxp2(p2_o[1]), .sample_valid(valid_o[1]), .timeout_err(to_o[1]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit run = 1'b0;
    int av [0:1];

    // Expected timeline, indexed by cycle number
    bit        e_den  [0:N-1];
    bit        e_aset [0:N-1];
    bit [6:0]  e_addr [0:N-1];
    bit        e_to   [0:N-1];
    bit        e_pub  [0:1][0:N-1];
    bit [15:0] e_v3   [0:1][0:N-1];
    bit [15:0] e_v2   [0:1][0:N-1];

    // Model state: sums and pair counts per instance
    int acc_l [0:1];
    int acc_r [0:1];
    int pcnt  [0:1];

    bit [6:0]  cur_addr;
    bit [15:0] cur3 [0:1];
    bit [15:0] cur2 [0:1];

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom & 1);
    endfunction

    function automatic logic [15:0] rw();
        return 16'($urandom);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            cur_addr = 7'h13;
            for (int d = 0; d < 2; d++) begin
                cur3[d] = 16'd0;
                cur2[d] = 16'd0;
            end
        end else if (run && cyc < N) begin
            if (e_aset[cyc]) cur_addr = e_addr[cyc];
            for (int d = 0; d < 2; d++) begin
                if (e_pub[d][cyc]) begin
                    cur3[d] = e_v3[d][cyc];
                    cur2[d] = e_v2[d][cyc];
                end
                chk("den_out",      d, int'(den_o[d]),   int'(e_den[cyc]));
                chk("dwe_out",      d, int'(dwe_o[d]),   0);
                chk("daddr_out",    d, int'(addr_o[d]),  int'(cur_addr));
                chk("sample_valid", d, int'(valid_o[d]), int'(e_pub[d][cyc]));
                chk("timeout_err",  d, int'(to_o[d]),    int'(e_to[cyc]));
                chk("vauxp3",       d, int'(p3_o[d]),    int'(cur3[d]));
                chk("vauxp2",       d, int'(p2_o[d]),    int'(cur2[d]));
            end
        end
    end

    task automatic tick(input logic e, input logic dr, input logic [15:0] v);
        eoc_in  = e;
        drdy_in = dr;
        do_in   = v;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= N - 2) begin
            errors++;
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, N - 2);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        eoc_in  = 1'b0;
        drdy_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_den",   d, int'(den_o[d]),   0);
            chk("rst_daddr", d, int'(addr_o[d]),  'h13);
            chk("rst_p3",    d, int'(p3_o[d]),    0);
            chk("rst_p2",    d, int'(p2_o[d]),    0);
            chk("rst_valid", d, int'(valid_o[d]), 0);
            chk("rst_to",    d, int'(to_o[d]),    0);
            acc_l[d] = 0;
            acc_r[d] = 0;
            pcnt[d]  = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
    endtask

    // Current cycle is the REQ cycle. d >= 0: response after d wait cycles;
    // d = -1: no response (timeout); d = -2: reset during the wait.
    task automatic read_ch(input logic [6:0] a, input int d, input logic [15:0] v, output bit ok);
        e_den[cyc]  = 1'b1;
        e_aset[cyc] = 1'b1;
        e_addr[cyc] = a;
        tick(rb(), rb(), rw());
        ok = 1'b0;
        if (d == -2) begin
            tick(rb(), 1'b0, rw());
            tick(rb(), 1'b0, rw());
            do_reset();
        end else if (d < 0) begin
            repeat (T) tick(rb(), 1'b0, rw());
            e_to[cyc] = 1'b1;
            tick(rb(), 1'b0, rw());
        end else begin
            repeat (d) tick(rb(), 1'b0, rw());
            tick(rb(), 1'b1, v);
            ok = 1'b1;
        end
    endtask

    task automatic model_pair(input int l, input int r);
        for (int d = 0; d < 2; d++) begin
            acc_l[d] += l;
            acc_r[d] += r;
            pcnt[d]++;
            if (pcnt[d] == (1 << av[d])) begin
                e_pub[d][cyc] = 1'b1;
                e_v3[d][cyc]  = 16'(acc_l[d] / (1 << av[d]));
                e_v2[d][cyc]  = 16'(acc_r[d] / (1 << av[d]));
                acc_l[d] = 0;
                acc_r[d] = 0;
                pcnt[d]  = 0;
            end
        end
    endtask

    task automatic do_pair(input int dl, input int dr, input logic [15:0] vl, input logic [15:0] vr);
        bit ok;
        tick(1'b1, rb(), rw());
        read_ch(7'h13, dl, vl, ok);
        if (ok) begin
            read_ch(7'h12, dr, vr, ok);
            if (ok) model_pair(int'(vl[15:4]), int'(vr[15:4]));
        end
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom % 10);
        if (r == 0) return -1;
        if (r == 1) return T - 1;
        return int'($urandom % 4);
    endfunction

    function automatic logic [11:0] pick_val();
        int r;
        r = int'($urandom % 8);
        if (r == 0) return 12'd0;
        if (r == 1) return 12'hFFF;
        return 12'($urandom);
    endfunction

    initial begin
        av[0] = 0;
        av[1] = 2;
        for (int d = 0; d < 2; d++) begin
            acc_l[d] = 0;
            acc_r[d] = 0;
            pcnt[d]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("init_den",   d, int'(den_o[d]),   0);
            chk("init_daddr", d, int'(addr_o[d]),  'h13);
            chk("init_p3",    d, int'(p3_o[d]),    0);
            chk("init_valid", d, int'(valid_o[d]), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        run   = 1'b1;
        tick(1'b0, 1'b0, 16'h0000);

        do_pair(2, 3, 16'h7D00, 16'h3E80);
        chk("lit_single_p3", 0, int'(p3_o[0]), 2000);
        chk("lit_single_p2", 0, int'(p2_o[0]), 1000);

        do_reset();
        repeat (3) tick(1'b0, 1'b1, rw());
        do_pair(0, 1, 16'(100 << 4), 16'(4095 << 4));
        do_pair(1, 0, 16'(200 << 4), 16'(4095 << 4));
        do_pair(2, 2, 16'(300 << 4), 16'(4095 << 4));
        do_pair(0, 0, 16'(403 << 4), 16'(4095 << 4));
        chk("lit_avg4_p3", 1, int'(p3_o[1]), 250);
        chk("lit_avg4_p2", 1, int'(p2_o[1]), 4095);
        chk("lit_last_p3", 0, int'(p3_o[0]), 403);

        do_pair(1, -1, 16'h0FF0, 16'h0FF0);
        do_pair(0, 2, 16'h0640, 16'h0C80);
        chk("lit_after_to_p3", 0, int'(p3_o[0]), 100);
        chk("lit_after_to_p2", 0, int'(p2_o[0]), 200);

        do_pair(T - 1, T - 1, 16'h0FA5, 16'hFFFF);
        chk("lit_edge_p3", 0, int'(p3_o[0]), 250);
        chk("lit_edge_p2", 0, int'(p2_o[0]), 4095);

        do_pair(-1, 0, 16'h1230, 16'h4560);
        do_pair(1, -2, 16'h0AB0, 16'h0CD0);
        repeat (4) do_pair(0, 1, 16'h0080, 16'h00C0);
        chk("lit_post_rst_p3", 1, int'(p3_o[1]), 8);
        chk("lit_post_rst_p2", 1, int'(p2_o[1]), 12);

        for (int i = 0; i < 250; i++) begin
            int gap;
            do_pair(pick_delay(), pick_delay(), {pick_val(), 4'($urandom)}, {pick_val(), 4'($urandom)});
            gap = int'($urandom % 3);
            repeat (gap) tick(1'b0, rb(), rw());
        end
        repeat (4) tick(1'b0, 1'b0, 16'h0000);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
